decode_stage: RTL

- Parametrised instruction-decode stage for the pipelined MIPS core; successor to the combinational decode datapath.
- Contains the register file, early branch resolution with four compare modes, and 3-way operand forwarding (regfile / M / W) for the branch comparator.
- Also owns the registered D→E pipeline boundary, with flush-to-bubble and stall hold.
- Sits between the IF/ID register and the execute datapath; the hazard unit drives its forward/stall/flush inputs.

---
 rtl/decode_stage_if.sv | 56 +++++
 rtl/decode_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: bus between the IF/ID register, hazard unit, write-back
// path and the decode stage.
//   master : upstream side (drives instruction, PC, write-back, forwarding and
//            pipeline-control signals; observes branch/jump and E-stage state)
//   slave  : the decode stage itself
// Ports carried:
//   inst_D, pc_plus4_D          instruction in decode and its PC+4
//   reg_write_W/reg_id_W/result_W  write-back port into the register file
//   alu_out_M                   memory-stage ALU result (forwarding source)
//   fwdA_D/fwdB_D               branch-compare operand select
//   branch_D/br_mode_D          branch qualifier and compare mode
//   stall_E/flush_E             D->E register hold / bubble
//   pc_src_D/pc_br_D/pc_jmp_D   branch decision and targets
//   rs_E..valid_E               registered D->E pipeline contents
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic [31:0]     inst_D;
  logic [XLEN-1:0] pc_plus4_D;
  logic            reg_write_W;
  logic [RAW-1:0]  reg_id_W;
  logic [XLEN-1:0] result_W;
  logic [XLEN-1:0] alu_out_M;
  logic [1:0]      fwdA_D;
  logic [1:0]      fwdB_D;
  logic            branch_D;
  logic [1:0]      br_mode_D;
  logic            stall_E;
  logic            flush_E;

  logic            pc_src_D;
  logic [XLEN-1:0] pc_br_D;
  logic [XLEN-1:0] pc_jmp_D;
  logic [XLEN-1:0] rs_E;
  logic [XLEN-1:0] rt_E;
  logic [XLEN-1:0] imm_E;
  logic [RAW-1:0]  rs_id_E;
  logic [RAW-1:0]  rt_id_E;
  logic [RAW-1:0]  rd_id_E;
  logic            valid_E;

  modport master (
    output inst_D, pc_plus4_D, reg_write_W, reg_id_W, result_W, alu_out_M,
           fwdA_D, fwdB_D, branch_D, br_mode_D, stall_E, flush_E,
    input  pc_src_D, pc_br_D, pc_jmp_D, rs_E, rt_E, imm_E,
           rs_id_E, rt_id_E, rd_id_E, valid_E
  );

  modport slave (
    input  inst_D, pc_plus4_D, reg_write_W, reg_id_W, result_W, alu_out_M,
           fwdA_D, fwdB_D, branch_D, br_mode_D, stall_E, flush_E,
    output pc_src_D, pc_br_D, pc_jmp_D, rs_E, rt_E, imm_E,
           rs_id_E, rt_id_E, rd_id_E, valid_E
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction-decode stage.
//   Register file (NREG x XLEN, r0 hard-wired to zero, write-through bypass),
//   sign-extended immediate, branch/jump target generation, early branch
//   resolution (beq/bne/blez/bgtz) with M/W forwarding into the comparator,
//   and the registered D->E pipeline boundary with flush and stall.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears regfile and E stage)
//   bus    decode_stage_if.slave carrying all datapath/control signals
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = $clog2(NREG)
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  logic [XLEN-1:0] regs [NREG];

  logic [RAW-1:0]  rs_idx;
  logic [RAW-1:0]  rt_idx;
  logic [RAW-1:0]  rd_idx;
  logic [XLEN-1:0] rs_stored;
  logic [XLEN-1:0] rt_stored;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] imm_D;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            cond;
  logic            wr_ok;

  logic [XLEN-1:0] rs_q;
  logic [XLEN-1:0] rt_q;
  logic [XLEN-1:0] imm_q;
  logic [RAW-1:0]  rs_id_q;
  logic [RAW-1:0]  rt_id_q;
  logic [RAW-1:0]  rd_id_q;
  logic            valid_q;

  // Register index fields are cut down to RAW bits, so with a small register
  // file the upper index bits of the instruction are simply ignored.
  assign rs_idx = RAW'(bus.inst_D[25:21]);
  assign rt_idx = RAW'(bus.inst_D[20:16]);
  assign rd_idx = RAW'(bus.inst_D[15:11]);

  // Indices beyond NREG only exist when NREG is not a power of two; they are
  // treated as non-existent registers (never written, read as zero).
  assign wr_ok = bus.reg_write_W && (bus.reg_id_W != '0) && (32'(bus.reg_id_W) < NREG);

  assign rs_stored = (32'(rs_idx) < NREG) ? regs[rs_idx] : '0;
  assign rt_stored = (32'(rt_idx) < NREG) ? regs[rt_idx] : '0;

  // A read of the register being written this cycle returns the incoming
  // write-back value, so decode never sees a stale value one cycle late.
  function automatic logic [XLEN-1:0] read_port(
    input logic [RAW-1:0]  idx,
    input logic [XLEN-1:0] stored
  );
    if (idx == '0 || 32'(idx) >= NREG) return '0;
    if (wr_ok && bus.reg_id_W == idx)   return bus.result_W;
    return stored;
  endfunction

  assign rs_data = read_port(rs_idx, rs_stored);
  assign rt_data = read_port(rt_idx, rt_stored);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.reg_id_W] <= bus.result_W;
    end
  end

  assign imm_D        = {{(XLEN-16){bus.inst_D[15]}}, bus.inst_D[15:0]};
  assign bus.pc_br_D  = bus.pc_plus4_D + (imm_D << 2);
  assign bus.pc_jmp_D = {bus.pc_plus4_D[XLEN-1:28], bus.inst_D[25:0], 2'b00};

  // Branch comparator: each operand may come from the regfile, the M-stage
  // ALU result or the W-stage result; select code 11 falls back to regfile.
  // blez/bgtz only look at operand A, using its sign bit and a zero test.
  always_comb begin
    cmp_a = rs_data;
    case (bus.fwdA_D)
      2'b01:   cmp_a = bus.alu_out_M;
      2'b10:   cmp_a = bus.result_W;
      default: cmp_a = rs_data;
    endcase
    cmp_b = rt_data;
    case (bus.fwdB_D)
      2'b01:   cmp_b = bus.alu_out_M;
      2'b10:   cmp_b = bus.result_W;
      default: cmp_b = rt_data;
    endcase
    cond = 1'b0;
    case (bus.br_mode_D)
      2'b00:   cond = (cmp_a == cmp_b);
      2'b01:   cond = (cmp_a != cmp_b);
      2'b10:   cond = cmp_a[XLEN-1] || (cmp_a == '0);
      default: cond = !cmp_a[XLEN-1] && (cmp_a != '0);
    endcase
  end

  assign bus.pc_src_D = bus.branch_D && cond;

  // D->E boundary: flush beats stall. Only raw regfile read data is carried
  // forward; forwarded comparator values are used for branching only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      rs_id_q <= '0;
      rt_id_q <= '0;
      rd_id_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush_E) begin
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      rs_id_q <= '0;
      rt_id_q <= '0;
      rd_id_q <= '0;
      valid_q <= 1'b0;
    end else if (!bus.stall_E) begin
      rs_q    <= rs_data;
      rt_q    <= rt_data;
      imm_q   <= imm_D;
      rs_id_q <= rs_idx;
      rt_id_q <= rt_idx;
      rd_id_q <= rd_idx;
      valid_q <= 1'b1;
    end
  end

  assign bus.rs_E    = rs_q;
  assign bus.rt_E    = rt_q;
  assign bus.imm_E   = imm_q;
  assign bus.rs_id_E = rs_id_q;
  assign bus.rt_id_E = rt_id_q;
  assign bus.rd_id_E = rd_id_q;
  assign bus.valid_E = valid_q;

endmodule
